jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller for the RISC-V debug transport module.
- Tracks the 16-state TAP FSM from TMS and holds a 5-bit instruction register (IR).
- Decodes the IR into one-hot selects for the DTMCS, DMI, IDCODE and BYPASS data registers, and drives their shared capture/shift/update strobes.
- Sits between the JTAG pins and the DTM data registers; contains the IDCODE and BYPASS registers internally.

---
 rtl/jtag_pkg.sv | 44 ++++
 rtl/jtag_tap_ctrl_if.sv | 30 +++
 rtl/jtag_tap_fsm.sv | 49 ++++
 rtl/jtag_tap_ctrl.sv | 130 +++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: types and constants shared by the RISC-V debug transport TAP
// controller and the DTM data registers that sit behind it.
package jtag_pkg;

  // Instruction register geometry and codes.
  localparam int unsigned         IR_WIDTH     = 5;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE    = 5'h01;
  localparam logic [IR_WIDTH-1:0] IR_DTMCS     = 5'h10;
  localparam logic [IR_WIDTH-1:0] IR_DMI       = 5'h11;
  localparam logic [IR_WIDTH-1:0] IR_BYPASS    = 5'h1F;

  // Default IDCODE; bit 0 is always 1 as the JTAG standard requires.
  localparam logic [31:0]         IDCODE_VALUE = 32'h0000_0001;

  // DTMCS fields shared with the DTMCS register implementation.
  localparam logic [3:0]          DTM_VERSION  = 4'd1;
  localparam logic [5:0]          DMI_ABITS    = 6'd7;

  // The 16 TAP states, using the encoding from the 1149.1 reference design.
  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  // True in the two states where TDO carries scan data.
  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: JTAG pin-side and DTM-side signals of the TAP controller.
// The slave modport is the TAP controller; master is the pin driver / DTM side.
interface jtag_tap_ctrl_if;

  logic i_tms;
  logic i_tdi;
  logic o_tdo;
  logic o_tdo_en;
  logic i_dtmcs_tdo;
  logic i_dmi_tdo;
  logic o_capture;
  logic o_shift;
  logic o_update;
  logic o_sel_dtmcs;
  logic o_sel_dmi;
  logic o_tap_reset;

  modport slave (
    input  i_tms, i_tdi, i_dtmcs_tdo, i_dmi_tdo,
    output o_tdo, o_tdo_en, o_capture, o_shift, o_update,
           o_sel_dtmcs, o_sel_dmi, o_tap_reset
  );

  modport master (
    output i_tms, i_tdi, i_dtmcs_tdo, i_dmi_tdo,
    input  o_tdo, o_tdo_en, o_capture, o_shift, o_update,
           o_sel_dtmcs, o_sel_dmi, o_tap_reset
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: the 16-state 1149.1 TAP state machine, advanced by TMS on
// every rising TCK. Five TMS=1 cycles reach Test-Logic-Reset from anywhere.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output tap_state_t state,
  output logic       o_tap_reset
);

  tap_state_t state_nxt;

  // Next-state graph of the standard TAP controller.
  always_comb begin
    // NOTE: the default assignment first guarantees no latch is inferred.
    state_nxt = state;
    unique case (state)
      TLR:    state_nxt = i_tms ? TLR    : RTI;
      RTI:    state_nxt = i_tms ? SEL_DR : RTI;
      SEL_DR: state_nxt = i_tms ? SEL_IR : CAP_DR;
      CAP_DR: state_nxt = i_tms ? EX1_DR : SH_DR;
      SH_DR:  state_nxt = i_tms ? EX1_DR : SH_DR;
      EX1_DR: state_nxt = i_tms ? UPD_DR : PA_DR;
      PA_DR:  state_nxt = i_tms ? EX2_DR : PA_DR;
      EX2_DR: state_nxt = i_tms ? UPD_DR : SH_DR;
      UPD_DR: state_nxt = i_tms ? SEL_DR : RTI;
      SEL_IR: state_nxt = i_tms ? TLR    : CAP_IR;
      CAP_IR: state_nxt = i_tms ? EX1_IR : SH_IR;
      SH_IR:  state_nxt = i_tms ? EX1_IR : SH_IR;
      EX1_IR: state_nxt = i_tms ? UPD_IR : PA_IR;
      PA_IR:  state_nxt = i_tms ? EX2_IR : PA_IR;
      EX2_IR: state_nxt = i_tms ? UPD_IR : SH_IR;
      UPD_IR: state_nxt = i_tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // State register; TRST forces Test-Logic-Reset without waiting for TCK.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
    if (!i_trst_n) state <= TLR;
    else           state <= state_nxt;
  end

  assign o_tap_reset = (state == TLR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller for the RISC-V debug transport
// module. Holds the instruction register, decodes it into data-register
// selects, owns the BYPASS (and optionally IDCODE) registers, and drives the
// shared capture/shift/update strobes and the negedge-registered TDO.
//
// Build option: define JTAG_IDCODE_EN to include the 32-bit IDCODE register.
// Without it the IDCODE instruction falls through to BYPASS; the IR still
// resets to the IDCODE code either way.
module jtag_tap_ctrl #(
  parameter int unsigned         IR_WIDTH     = jtag_pkg::IR_WIDTH,
  parameter logic [31:0]         IDCODE_VALUE = jtag_pkg::IDCODE_VALUE,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE    = IR_WIDTH'(jtag_pkg::IR_IDCODE),
  parameter logic [IR_WIDTH-1:0] IR_DTMCS     = IR_WIDTH'(jtag_pkg::IR_DTMCS),
  parameter logic [IR_WIDTH-1:0] IR_DMI       = IR_WIDTH'(jtag_pkg::IR_DMI)
) (
  input  logic           i_tck,
  input  logic           i_trst_n,
  jtag_tap_ctrl_if.slave tap
);

  import jtag_pkg::*;

  tap_state_t          state;
  logic                tap_reset;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir;
  logic                sel_dtmcs;
  logic                sel_dmi;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                idcode_tdo;
  logic                bypass_q;
  logic                tdo_src;
  logic                tdo_q;
  logic                tdo_en_q;

  jtag_tap_fsm u_fsm (
    .i_tck       (i_tck),
    .i_trst_n    (i_trst_n),
    .i_tms       (tap.i_tms),
    .state       (state),
    .o_tap_reset (tap_reset)
  );

  // IR scan path: capture the fixed 0..01 pattern, then shift LSB-first.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n)             ir_shift <= '0;
    else if (state == CAP_IR)  ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
    else if (state == SH_IR)   ir_shift <= {tap.i_tdi, ir_shift[IR_WIDTH-1:1]};
  end

  // Active IR: only Update-IR and Test-Logic-Reset change it, so a paused or
  // aborted scan never disturbs the current selection.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n)             ir <= IR_IDCODE;
    else if (state == TLR)     ir <= IR_IDCODE;
    else if (state == UPD_IR)  ir <= ir_shift;
  end

  assign sel_dtmcs = (ir == IR_DTMCS);
  assign sel_dmi   = (ir == IR_DMI);

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_sr;

  assign sel_idcode = (ir == IR_IDCODE);

  // IDCODE register: parallel load on capture, shift toward bit 0 on shift.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n)                         idcode_sr <= '0;
    else if (sel_idcode && state == CAP_DR) idcode_sr <= IDCODE_VALUE;
    else if (sel_idcode && state == SH_DR)  idcode_sr <= {tap.i_tdi, idcode_sr[31:1]};
  end

  assign idcode_tdo = idcode_sr[0];
`else
  logic unused_idcode;

  // No IDCODE register: the IDCODE instruction is treated like any unknown
  // code and lands on BYPASS.
  assign sel_idcode    = 1'b0;
  assign idcode_tdo    = 1'b0;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  // Everything not claimed above, including all-ones, is BYPASS.
  assign sel_bypass = !(sel_dtmcs || sel_dmi || sel_idcode);

  // BYPASS register: a single stage that captures 0 and then tracks TDI.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n)                          bypass_q <= 1'b0;
    else if (sel_bypass && state == CAP_DR) bypass_q <= 1'b0;
    else if (sel_bypass && state == SH_DR)  bypass_q <= tap.i_tdi;
  end

  // TDO source: IR scan bit, selected DR bit 0, or 0 outside the shift states.
  always_comb begin
    tdo_src = 1'b0;
    if (state == SH_IR) begin
      tdo_src = ir_shift[0];
    end else if (state == SH_DR) begin
      if (sel_dtmcs)       tdo_src = tap.i_dtmcs_tdo;
      else if (sel_dmi)    tdo_src = tap.i_dmi_tdo;
      else if (sel_idcode) tdo_src = idcode_tdo;
      else if (sel_bypass) tdo_src = bypass_q;
    end
  end

  // TDO is launched on the falling edge so the probe samples it mid-cycle.
  always_ff @(negedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_src;
      tdo_en_q <= is_shift_state(state);
    end
  end

  // Strobes are plain state decodes; each DR gates them with its own select.
  assign tap.o_capture   = (state == CAP_DR);
  assign tap.o_shift     = (state == SH_DR);
  assign tap.o_update    = (state == UPD_DR);
  assign tap.o_sel_dtmcs = sel_dtmcs;
  assign tap.o_sel_dmi   = sel_dmi;
  assign tap.o_tap_reset = tap_reset;
  assign tap.o_tdo       = tdo_q;
  assign tap.o_tdo_en    = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: randomized scans against a bit-queue model of the TAP's
// scan registers; a monitor compares every TDO bit presented while o_tdo_en
// is high against the queue of expected bits pushed by the stimulus.
module tb_jtag_tap_ctrl;
  import jtag_pkg::*;

  logic tck = 1'b0;
  logic trst_n;

  jtag_tap_ctrl_if bus ();

  jtag_tap_ctrl dut (
    .i_tck    (tck),
    .i_trst_n (trst_n),
    .tap      (bus)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_pass   = 0;

  bit exp_q[$];      // expected TDO bits, oldest first
  bit sq[$];         // model of the active scan register, bit 0 at front
  bit mon_en  = 1'b0;
  bit scan_ir = 1'b0;
  logic [IR_WIDTH-1:0] m_ir;

  int cnt_cap = 0;
  int cnt_sh  = 0;
  int cnt_upd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  // Monitor: one sample per TCK cycle, just after TDO is launched.
  initial forever begin
    @(negedge tck);
    #1;
    cnt_cap += int'(bus.o_capture);
    cnt_sh  += int'(bus.o_shift);
    cnt_upd += int'(bus.o_update);
    if (mon_en && bus.o_tdo_en) begin
      if (exp_q.size() == 0) begin
        check("tdo_unexpected", 32'(bus.o_tdo_en), 32'd0);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("tdo", 32'(bus.o_tdo), 32'(e));
      end
    end
  end

  function automatic bit expected_src(input logic dt, input logic dm);
    if (scan_ir)              return sq[0];
    else if (m_ir == IR_DTMCS) return dt;
    else if (m_ir == IR_DMI)   return dm;
    else                       return sq[0];
  endfunction

  // One TCK cycle. sh_now: the cycle is spent in a shift state; emit: the
  // cycle ends in a shift state, so TDO will present a bit at its negedge.
  task automatic cyc(input logic tms, input logic tdi, input bit sh_now, input bit emit);
    logic dt, dm;
    dt = 1'($urandom);
    dm = 1'($urandom);
    bus.i_tms       = tms;
    bus.i_tdi       = tdi;
    bus.i_dtmcs_tdo = dt;
    bus.i_dmi_tdo   = dm;
    if (sh_now) begin
      void'(sq.pop_front());
      sq.push_back(tdi);
    end
    if (emit) exp_q.push_back(expected_src(dt, dm));
    @(posedge tck);
    @(negedge tck);
    #2;
  endtask

  // Full IR or DR scan from Run-Test/Idle back to Run-Test/Idle, optionally
  // pausing after bit pause_at.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] data, input int pause_at);
    int c0, s0, u0;
    logic [31:0] idv;
    idv     = IDCODE_VALUE;
    scan_ir = is_ir;
    c0 = cnt_cap; s0 = cnt_sh; u0 = cnt_upd;
    cyc(1'b1, 1'b0, 0, 0);
    if (is_ir) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    sq.delete();
    if (is_ir) begin
      for (int i = 0; i < int'(IR_WIDTH); i++) sq.push_back(i == 0);
    end else begin
`ifdef JTAG_IDCODE_EN
      if (m_ir == IR_IDCODE) for (int i = 0; i < 32; i++) sq.push_back(idv[i]);
      else                   sq.push_back(1'b0);
`else
      sq.push_back(1'b0);
`endif
    end
    cyc(1'b0, 1'b0, 0, 1);
    for (int i = 0; i < n; i++) begin
      bit last, brk;
      last = (i == n - 1);
      brk  = last || (i == pause_at);
      cyc(brk, data[i], 1, !brk);
      if (brk && !last) begin
        cyc(1'b0, 1'b0, 0, 0);
        repeat (2) cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1);
      end
    end
    if (is_ir) for (int k = 0; k < int'(IR_WIDTH); k++) m_ir[k] = sq[k];
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    check("tdo_bits_pending", 32'(exp_q.size()), 32'd0);
    check("capture_pulses",   32'(cnt_cap - c0), is_ir ? 32'd0 : 32'd1);
    check("shift_pulses",     32'(cnt_sh - s0),  is_ir ? 32'd0 : 32'(n));
    check("update_pulses",    32'(cnt_upd - u0), is_ir ? 32'd0 : 32'd1);
    check("sel_dtmcs", 32'(bus.o_sel_dtmcs), 32'(m_ir == IR_DTMCS));
    check("sel_dmi",   32'(bus.o_sel_dmi),   32'(m_ir == IR_DMI));
    check("tap_reset_idle", 32'(bus.o_tap_reset), 32'd0);
  endtask

  function automatic logic [IR_WIDTH-1:0] pick_ir();
    case ($urandom_range(4, 0))
      0:       return IR_IDCODE;
      1:       return IR_DTMCS;
      2:       return IR_DMI;
      3:       return IR_BYPASS;
      default: return IR_WIDTH'($urandom);
    endcase
  endfunction

  task automatic random_dr();
    int n, p;
    n = int'($urandom_range(40, 1));
    p = (n > 1 && $urandom_range(1, 0) == 1) ? int'($urandom_range(n - 2, 0)) : -1;
    scan(1'b0, n, {$urandom, $urandom}, p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exceeded, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int c0, s0, u0;
    bus.i_tms = 1'b1; bus.i_tdi = 1'b0; bus.i_dtmcs_tdo = 1'b0; bus.i_dmi_tdo = 1'b0;
    trst_n = 1'b0;
    #23;
    check("rst_tap_reset", 32'(bus.o_tap_reset), 32'd1);
    check("rst_tdo",       32'(bus.o_tdo),       32'd0);
    check("rst_tdo_en",    32'(bus.o_tdo_en),    32'd0);
    check("rst_strobes",   32'({bus.o_capture, bus.o_shift, bus.o_update}), 32'd0);
    check("rst_sels",      32'({bus.o_sel_dtmcs, bus.o_sel_dmi}), 32'd0);
    trst_n = 1'b1;
    @(negedge tck); #2;
    check("rel_tap_reset", 32'(bus.o_tap_reset), 32'd1);
    check("rel_tdo_en",    32'(bus.o_tdo_en),    32'd0);
    m_ir = IR_IDCODE;
    cyc(1'b0, 1'b0, 0, 0);
    mon_en = 1'b1;

    // DR scan straight after reset: IDCODE value or the lone bypass bit.
    scan(1'b0, 32, {$urandom, $urandom}, -1);
    // Select DTMCS; the captured IR pattern 00001 comes out first.
    scan(1'b1, 5, 64'h10, -1);
    scan(1'b0, 12, {$urandom, $urandom}, 5);
    // BYPASS with pattern 1,0,1,1 -> 0,1,0,1.
    scan(1'b1, 5, 64'(IR_BYPASS), -1);
    scan(1'b0, 4, 64'b1101, -1);

    // Idling in Run-Test/Idle raises no strobes.
    c0 = cnt_cap; s0 = cnt_sh; u0 = cnt_upd;
    repeat (20) cyc(1'b0, 1'($urandom), 0, 0);
    check("idle_no_capture", 32'(cnt_cap - c0), 32'd0);
    check("idle_no_shift",   32'(cnt_sh - s0),  32'd0);
    check("idle_no_update",  32'(cnt_upd - u0), 32'd0);

    // Randomized IR selects with extra leading bits, then DR scans.
    for (int t = 0; t < 30; t++) begin
      int n;
      logic [63:0] d;
      n = int'($urandom_range(9, 5));
      d = (64'(pick_ir()) << (n - 5)) | (64'($urandom) & ((64'd1 << (n - 5)) - 64'd1));
      scan(1'b1, n, d, (n > 1 && $urandom_range(1, 0) == 1) ? int'($urandom_range(n - 2, 0)) : -1);
      random_dr();
    end

    // Five TMS=1 cycles reach Test-Logic-Reset from a random state.
    for (int t = 0; t < 4; t++) begin
      mon_en = 1'b0;
      repeat ($urandom_range(12, 0)) cyc(1'($urandom), 1'($urandom), 0, 0);
      repeat (5) cyc(1'b1, 1'b0, 0, 0);
      check("tms5_tap_reset", 32'(bus.o_tap_reset), 32'd1);
      check("tms5_sels",      32'({bus.o_sel_dtmcs, bus.o_sel_dmi}), 32'd0);
      m_ir = IR_IDCODE;
      exp_q.delete();
      cyc(1'b0, 1'b0, 0, 0);
      mon_en = 1'b1;
      random_dr();
      scan(1'b1, 5, 64'(pick_ir()), -1);
    end

    // TRST in the middle of a DTMCS shift aborts the scan at once.
    scan(1'b1, 5, 64'(IR_DTMCS), -1);
    mon_en = 1'b0;
    u0 = cnt_upd;
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    bus.i_tms = 1'b0; bus.i_dtmcs_tdo = 1'b1;
    @(posedge tck); @(negedge tck); #2;
    check("pre_abort_tdo", 32'(bus.o_tdo), 32'd1);
    trst_n = 1'b0;
    #1;
    check("abort_tdo",       32'(bus.o_tdo),       32'd0);
    check("abort_tdo_en",    32'(bus.o_tdo_en),    32'd0);
    check("abort_tap_reset", 32'(bus.o_tap_reset), 32'd1);
    check("abort_shift",     32'(bus.o_shift),     32'd0);
    check("abort_sel_dtmcs", 32'(bus.o_sel_dtmcs), 32'd0);
    @(negedge tck); #2;
    trst_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 0, 0);
    check("abort_no_update", 32'(cnt_upd - u0), 32'd0);
    check("abort_in_tlr",    32'(bus.o_tap_reset), 32'd1);
    m_ir = IR_IDCODE;
    exp_q.delete();
    cyc(1'b0, 1'b0, 0, 0);
    mon_en = 1'b1;
    scan(1'b0, 33, {$urandom, $urandom}, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
